// File: rtl/apb4_wait_regfile.sv
// APB4 completer register file: byte-strobed writes, programmable wait states, PSLVERR on bad access.
// Latency: PREADY rises WAIT_STATES cycles after the first PENABLE cycle; a write lands on the edge ending that cycle.
// Backpressure: PREADY is held low for WAIT_STATES access cycles; the requester keeps the bus stable until PREADY.
// Optional build macro APB4_REGFILE_PPROT_CHECK_EN: reject nonsecure/unprivileged accesses at index >= SECURE_BASE.
module apb4_wait_regfile #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 0,
    parameter int SECURE_BASE = 8
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic [ADDR_W-1:0]            PADDR,
    input  logic                         PWRITE,
    input  logic [DATA_W-1:0]            PWDATA,
    input  logic [DATA_W/8-1:0]          PSTRB,
    input  logic [2:0]                   PPROT,
    output logic [DATA_W-1:0]            PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_pulse
);
    localparam int NB  = DATA_W / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = ADDR_W - LSB;
    localparam int SW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt;
    logic [SW-1:0]       idx_q;
    logic                err_q;
    logic                wr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NB-1:0]       strb_q;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic [IW-1:0]       idx;
    logic                unaligned;
    logic                range_err;
    logic                prot_err;
    logic                dec_err;
    logic                setup;
    logic                access;
    logic                commit;

    assign idx       = PADDR[ADDR_W-1:LSB];
    assign range_err = (32'(idx) >= 32'(NUM_REGS));
    assign dec_err   = unaligned | range_err | prot_err;
    assign setup     = PSEL & ~PENABLE;
    assign access    = PSEL & PENABLE;

    // Byte-wide registers have no sub-word offset bits to check.
    generate
        if (LSB > 0) begin : g_align
            assign unaligned = |PADDR[LSB-1:0];
        end else begin : g_no_align
            assign unaligned = 1'b0;
        end
    endgenerate

`ifdef APB4_REGFILE_PPROT_CHECK_EN
    logic unused_prot;
    assign prot_err    = (32'(idx) >= 32'(SECURE_BASE)) & (PPROT[1] | ~PPROT[0]);
    assign unused_prot = PPROT[2];
`else
    logic unused_prot;
    assign prot_err    = 1'b0;
    assign unused_prot = (^PPROT) ^ (SECURE_BASE > 0);
`endif

    // Next state and PREADY; DONE accepts a back-to-back setup exactly like IDLE.
    always_comb begin
        state_nxt = state;
        PREADY    = 1'b0;
        case (state)
            IDLE, DONE: state_nxt = setup ? ACCESS : IDLE;
            ACCESS: begin
                if (!access) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd0) begin
                    PREADY    = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, setup-phase capture and wait-state countdown.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE || state == DONE) && setup) begin
                idx_q   <= idx[SW-1:0];
                err_q   <= dec_err;
                wr_q    <= PWRITE;
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
                cnt     <= 4'(WAIT_STATES);
            end else if (state == ACCESS && access && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign commit = PREADY & wr_q & ~err_q;

    // Register storage with per-lane write enables; wr_pulse fires even when no lane is enabled.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                wr_pulse[idx_q] <= 1'b1;
                for (int b = 0; b < NB; b++) begin
                    if (strb_q[b]) regs[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    assign PRDATA  = (PREADY & ~err_q & ~wr_q) ? regs[idx_q] : '0;
    assign PSLVERR = PREADY & err_q;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign reg_q[gi*DATA_W +: DATA_W] = regs[gi];
        end
    endgenerate
endmodule

// File: tb/tb_apb4_wait_regfile.sv
module tb_apb4_wait_regfile;
    typedef struct packed {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [2:0]  pr;
    } txn_t;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        int          waits;
        logic [15:0] pulse;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  psel;
    logic        penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;

    logic [31:0]  prdata  [2];
    logic         pready  [2];
    logic         pslverr [2];
    logic [511:0] regq    [2];
    logic [15:0]  pulse   [2];

    int          ws [2] = '{0, 3};
    logic [31:0] mdl [2][16];
    exp_t        sbq [$];
    int          n_vec = 0;
    int          n_bad = 0;

    apb4_wait_regfile #(.ADDR_W(12), .DATA_W(32), .NUM_REGS(16), .WAIT_STATES(0), .SECURE_BASE(8)) u_ws0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
        .reg_q(regq[0]), .wr_pulse(pulse[0])
    );

    apb4_wait_regfile #(.ADDR_W(12), .DATA_W(32), .NUM_REGS(16), .WAIT_STATES(3), .SECURE_BASE(8)) u_ws3 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
        .reg_q(regq[1]), .wr_pulse(pulse[1])
    );

    // Reference model: decode, error rules, strobed update, expected response.
    function automatic exp_t predict(input int inst, input txn_t t);
        exp_t e;
        int   idx;
        logic err;
        idx = int'(t.addr[11:2]);
        err = (t.addr[1:0] != 2'b00) || (idx >= 16);
`ifdef APB4_REGFILE_PPROT_CHECK_EN
        if (idx >= 8 && (t.pr[1] || !t.pr[0])) err = 1'b1;
`endif
        e.err   = err;
        e.waits = ws[inst];
        e.rd    = 32'h0;
        e.pulse = 16'h0;
        if (!err) begin
            if (t.wr) begin
                e.pulse = 16'd1 << idx;
                for (int b = 0; b < 4; b++)
                    if (t.st[b]) mdl[inst][idx][b*8 +: 8] = t.wd[b*8 +: 8];
            end else begin
                e.rd = mdl[inst][idx];
            end
        end
        return e;
    endfunction

    function automatic logic [511:0] model_flat(input int inst);
        logic [511:0] m;
        for (int r = 0; r < 16; r++) m[r*32 +: 32] = mdl[inst][r];
        return m;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 16; r++) mdl[i][r] = 32'h0;
    endfunction

    // One full APB transfer on one instance; reports data, error, wait count and the pulse window.
    task automatic apb_xfer(input int inst, input txn_t t, output logic [31:0] rd, output logic err,
                            output int waits, output logic [15:0] pa, output logic [15:0] pb,
                            output logic glitch);
        glitch = 1'b0;
        waits  = 0;
        @(posedge clk); #1;
        psel = 2'b00; psel[inst] = 1'b1; penable = 1'b0;
        pwrite = t.wr; paddr = t.addr; pwdata = t.wd; pstrb = t.st; pprot = t.pr;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        while (!pready[inst] && waits < 40) begin
            if (pslverr[inst] || prdata[inst] != 32'h0) glitch = 1'b1;
            waits++;
            @(negedge clk);
        end
        if (!pready[inst]) waits = -1;
        rd  = prdata[inst];
        err = pslverr[inst];
        @(posedge clk); #1;
        psel = 2'b00; penable = 1'b0;
        @(negedge clk);
        pa = pulse[inst];
        @(negedge clk);
        pb = pulse[inst];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({pready[i], pslverr[i], prdata[i]} !== 34'h0) begin
                n_bad++;
                $display("FAIL reset_bus[%0d] ready=%b err=%b rdata=%h, want all 0", i, pready[i], pslverr[i], prdata[i]);
            end
            n_vec++;
            if (regq[i] !== 512'h0 || pulse[i] !== 16'h0) begin
                n_bad++;
                $display("FAIL reset_regs[%0d] reg_q=%h wr_pulse=%h, want 0", i, regq[i], pulse[i]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (pready[0] !== 1'b0 || pready[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_ready got %b%b, want 00", pready[1], pready[0]);
        end
    endtask

    task automatic test_ws0_rw();
        txn_t tv [4];
        exp_t e;
        logic [31:0] rd; logic err; int w; logic [15:0] pa, pb; logic gl;
        tv = '{'{1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 3'b001},
               '{1'b0, 12'h004, 32'h0,        4'h0, 3'b001},
               '{1'b1, 12'h03C, 32'h12345678, 4'hF, 3'b001},
               '{1'b0, 12'h03C, 32'hFFFFFFFF, 4'hF, 3'b001}};
        foreach (tv[k]) begin
            sbq.push_back(predict(0, tv[k]));
            apb_xfer(0, tv[k], rd, err, w, pa, pb, gl);
            e = sbq.pop_front();
            n_vec++;
            if (rd !== e.rd || err !== e.err) begin
                n_bad++; $display("FAIL ws0_resp[%0d] rdata=%h err=%b, want %h %b", k, rd, err, e.rd, e.err);
            end
            n_vec++;
            if (w !== e.waits) begin
                n_bad++; $display("FAIL ws0_latency[%0d] waits=%0d, want %0d", k, w, e.waits);
            end
            n_vec++;
            if (pa !== e.pulse || pb !== 16'h0 || gl !== 1'b0) begin
                n_bad++; $display("FAIL ws0_pulse[%0d] pulse=%h then %h glitch=%b, want %h then 0", k, pa, pb, gl, e.pulse);
            end
            n_vec++;
            if (regq[0] !== model_flat(0)) begin
                n_bad++; $display("FAIL ws0_regs[%0d] reg_q=%h, want %h", k, regq[0], model_flat(0));
            end
        end
    endtask

    task automatic test_strobes();
        txn_t tv [5];
        exp_t e;
        logic [31:0] rd; logic err; int w; logic [15:0] pa, pb; logic gl;
        tv = '{'{1'b1, 12'h008, 32'hAAAAAAAA, 4'hF, 3'b001},
               '{1'b1, 12'h008, 32'h11223344, 4'h5, 3'b001},
               '{1'b0, 12'h008, 32'h0,        4'h0, 3'b001},
               '{1'b1, 12'h00C, 32'hFFFFFFFF, 4'h0, 3'b001},
               '{1'b0, 12'h00C, 32'h0,        4'hF, 3'b001}};
        foreach (tv[k]) begin
            sbq.push_back(predict(1, tv[k]));
            apb_xfer(1, tv[k], rd, err, w, pa, pb, gl);
            e = sbq.pop_front();
            n_vec++;
            if (rd !== e.rd || err !== e.err) begin
                n_bad++; $display("FAIL strb_resp[%0d] rdata=%h err=%b, want %h %b", k, rd, err, e.rd, e.err);
            end
            n_vec++;
            if (w !== e.waits) begin
                n_bad++; $display("FAIL strb_latency[%0d] waits=%0d, want %0d", k, w, e.waits);
            end
            n_vec++;
            if (pa !== e.pulse || pb !== 16'h0 || gl !== 1'b0) begin
                n_bad++; $display("FAIL strb_pulse[%0d] pulse=%h then %h glitch=%b, want %h then 0", k, pa, pb, gl, e.pulse);
            end
            n_vec++;
            if (regq[1] !== model_flat(1)) begin
                n_bad++; $display("FAIL strb_regs[%0d] reg_q=%h, want %h", k, regq[1], model_flat(1));
            end
        end
        n_vec++;
        if (regq[1][2*32 +: 32] !== 32'hAA22AA44) begin
            n_bad++; $display("FAIL strb_merge reg2=%h, want aa22aa44", regq[1][2*32 +: 32]);
        end
    endtask

    task automatic test_errors();
        txn_t tv [4];
        exp_t e;
        logic [31:0] rd; logic err; int w; logic [15:0] pa, pb; logic gl;
        tv = '{'{1'b0, 12'h040, 32'h0,        4'hF, 3'b001},
               '{1'b1, 12'h002, 32'hFFFFFFFF, 4'hF, 3'b001},
               '{1'b0, 12'h3FC, 32'h0,        4'hF, 3'b001},
               '{1'b1, 12'h045, 32'h5A5A5A5A, 4'hF, 3'b001}};
        foreach (tv[k]) begin
            sbq.push_back(predict(0, tv[k]));
            apb_xfer(0, tv[k], rd, err, w, pa, pb, gl);
            e = sbq.pop_front();
            n_vec++;
            if (rd !== e.rd || err !== e.err) begin
                n_bad++; $display("FAIL err_resp[%0d] rdata=%h err=%b, want %h %b", k, rd, err, e.rd, e.err);
            end
            n_vec++;
            if (w !== e.waits || pa !== e.pulse || gl !== 1'b0) begin
                n_bad++; $display("FAIL err_side[%0d] waits=%0d pulse=%h glitch=%b, want %0d %h 0", k, w, pa, gl, e.waits, e.pulse);
            end
            n_vec++;
            if (regq[0] !== model_flat(0)) begin
                n_bad++; $display("FAIL err_regs[%0d] reg_q=%h, want %h", k, regq[0], model_flat(0));
            end
        end
    endtask

    task automatic test_pprot();
        txn_t tv [4];
        exp_t e;
        logic [31:0] rd; logic err; int w; logic [15:0] pa, pb; logic gl;
        tv = '{'{1'b1, 12'h024, 32'h00000001, 4'hF, 3'b010},
               '{1'b1, 12'h024, 32'h00000001, 4'hF, 3'b001},
               '{1'b0, 12'h024, 32'h0,        4'hF, 3'b000},
               '{1'b0, 12'h024, 32'h0,        4'hF, 3'b001}};
        foreach (tv[k]) begin
            sbq.push_back(predict(0, tv[k]));
            apb_xfer(0, tv[k], rd, err, w, pa, pb, gl);
            e = sbq.pop_front();
            n_vec++;
            if (rd !== e.rd || err !== e.err) begin
                n_bad++; $display("FAIL prot_resp[%0d] rdata=%h err=%b, want %h %b", k, rd, err, e.rd, e.err);
            end
            n_vec++;
            if (pa !== e.pulse || regq[0] !== model_flat(0)) begin
                n_bad++; $display("FAIL prot_write[%0d] pulse=%h reg9=%h, want %h %h", k, pa, regq[0][9*32 +: 32], e.pulse, mdl[0][9]);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(posedge clk); #1;
        psel = 2'b01; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'h0BADF00D; pstrb = 4'hF; pprot = 3'b001;
        sbq.push_back(predict(0, '{1'b1, 12'h000, 32'h0BADF00D, 4'hF, 3'b001}));
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        e = sbq.pop_front();
        n_vec++;
        if (pready[0] !== 1'b1 || pslverr[0] !== e.err) begin
            n_bad++; $display("FAIL b2b_write ready=%b err=%b, want 1 %b", pready[0], pslverr[0], e.err);
        end
        @(posedge clk); #1;
        penable = 1'b0; pwrite = 1'b0;
        sbq.push_back(predict(0, '{1'b0, 12'h000, 32'h0, 4'hF, 3'b001}));
        @(negedge clk);
        n_vec++;
        if (pulse[0] !== 16'h0001 || pready[0] !== 1'b0) begin
            n_bad++; $display("FAIL b2b_pulse wr_pulse=%h ready=%b, want 0001 0", pulse[0], pready[0]);
        end
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        e = sbq.pop_front();
        n_vec++;
        if (pready[0] !== 1'b1 || prdata[0] !== e.rd || pulse[0] !== 16'h0) begin
            n_bad++; $display("FAIL b2b_read ready=%b rdata=%h pulse=%h, want 1 %h 0000", pready[0], prdata[0], pulse[0], e.rd);
        end
        @(posedge clk); #1;
        psel = 2'b00; penable = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h12345678; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        n_vec++;
        if (pready[1] !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_wait ready=%b, want 0", pready[1]);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (regq[0] !== 512'h0 || regq[1] !== 512'h0 || pulse[1] !== 16'h0) begin
            n_bad++; $display("FAIL rstmid_clear reg_q0=%h reg_q1=%h pulse=%h, want 0", regq[0], regq[1], pulse[1]);
        end
        n_vec++;
        if ({pready[1], pslverr[1], prdata[1]} !== 34'h0) begin
            n_bad++; $display("FAIL rstmid_bus ready=%b err=%b rdata=%h, want 0", pready[1], pslverr[1], prdata[1]);
        end
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1; psel = 2'b00; penable = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (regq[1] !== 512'h0 || pulse[1] !== 16'h0) begin
            n_bad++; $display("FAIL rstmid_discard reg_q=%h pulse=%h, want 0", regq[1], pulse[1]);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        logic [31:0] rd; logic err; int w; logic [15:0] pa, pb; logic gl;
        sbq.push_back(predict(1, '{1'b1, 12'h000, 32'h0F0F0F0F, 4'hF, 3'b001}));
        apb_xfer(1, '{1'b1, 12'h000, 32'h0F0F0F0F, 4'hF, 3'b001}, rd, err, w, pa, pb, gl);
        e = sbq.pop_front();
        n_vec++;
        if (err !== e.err || pa !== e.pulse || w !== e.waits) begin
            n_bad++; $display("FAIL abort_prep err=%b pulse=%h waits=%0d, want %b %h %0d", err, pa, w, e.err, e.pulse, e.waits);
        end
        @(posedge clk); #1;
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'h00000055; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        n_vec++;
        if (pready[1] !== 1'b0) begin
            n_bad++; $display("FAIL abort_wait ready=%b, want 0", pready[1]);
        end
        @(posedge clk); #1;
        penable = 1'b0; psel = 2'b00;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (pready[1] !== 1'b0 || pulse[1] !== 16'h0) gl = 1'b1;
        end
        n_vec++;
        if (regq[1] !== model_flat(1) || gl === 1'b1) begin
            n_bad++; $display("FAIL abort_nowrite reg0=%h stray=%b, want %h 0", regq[1][31:0], gl, mdl[1][0]);
        end
        sbq.push_back(predict(1, '{1'b0, 12'h000, 32'h0, 4'h0, 3'b001}));
        apb_xfer(1, '{1'b0, 12'h000, 32'h0, 4'h0, 3'b001}, rd, err, w, pa, pb, gl);
        e = sbq.pop_front();
        n_vec++;
        if (rd !== e.rd || err !== e.err || w !== e.waits) begin
            n_bad++; $display("FAIL abort_read rdata=%h err=%b waits=%0d, want %h %b %0d", rd, err, w, e.rd, e.err, e.waits);
        end
    endtask

    initial begin
        psel = 2'b00; penable = 1'b0; pwrite = 1'b0; paddr = 12'h0;
        pwdata = 32'h0; pstrb = 4'h0; pprot = 3'b001; rst_n = 1'b0;
        model_clear();
        test_reset();
        test_ws0_rw();
        test_strobes();
        test_errors();
        test_pprot();
        test_back_to_back();
        test_reset_mid();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end
endmodule
